// File: rtl/seq_mult_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_pipe_ctrl
// Shift-and-add sequential multiplier with a valid/ready handshake on both
// sides. One operation is in flight at a time. Each accepted operand pair
// takes exactly WIDTH BUSY steps (no early exit). The product is then held in
// DONE until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair presented
//   in_ready   block is IDLE and can accept an operand pair
//   in1, in2   multiplier / multiplicand (WIDTH bits)
//   is_signed  treat operands as two's complement (ignored if SIGNED_EN==0)
//   out_valid  out holds a finished product (DONE state)
//   out_ready  consumer accepts out
//   out        product (2*WIDTH bits), two's complement for signed operations
//   busy       high in BUSY and DONE
// ---------------------------------------------------------------------------
module seq_mult_pipe_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Magnitude of a possibly-signed operand; the most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                             input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      f_mag = ~v + WIDTH'(1);
    end else begin
      f_mag = v;
    end
  endfunction

  // Power-up values match the reset values.
  state_t          r_state     = S_IDLE;
  logic [WIDTH-1:0] r_a        = '0;
  logic [PW-1:0]   r_b         = '0;
  logic [PW-1:0]   r_acc       = '0;
  logic [PW-1:0]   r_out       = '0;
  logic [CW-1:0]   r_cnt       = '0;
  logic            r_neg       = 1'b0;
  logic            r_in_ready  = 1'b1;
  logic            r_out_valid = 1'b0;
  logic            r_busy      = 1'b0;

  logic            w_sgn;
  logic [PW-1:0]   w_acc_step;
  logic [PW-1:0]   w_result;

  assign w_sgn      = (SIGNED_EN != 0) ? is_signed : 1'b0;
  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  assign w_acc_step = r_a[0] ? (r_acc + r_b) : r_acc;
  // Final step applies the stored sign to the unsigned magnitude product.
  assign w_result   = r_neg ? (~w_acc_step + PW'(1)) : w_acc_step;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out       = r_out;

  // Control FSM and datapath registers; reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the handshake.
          if (in_valid) begin
            r_a        <= f_mag(in1, w_sgn);
            r_b        <= {{WIDTH{1'b0}}, f_mag(in2, w_sgn)};
            r_neg      <= w_sgn & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= S_BUSY;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_BUSY: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_acc       <= w_result;
            r_out       <= w_result;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_acc <= w_acc_step;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean IDLE.
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_pipe_ctrl
// Scoreboard bench: the stimulus pushes the expected product when an operand
// pair is accepted. A negedge monitor pops and compares on every output
// handshake, and it checks accept-to-out_valid latency.
// ---------------------------------------------------------------------------
module tb_seq_mult_pipe_ctrl;

  localparam int WIDTH = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in1;
  logic [WIDTH-1:0]    in2;
  logic                is_signed;
  logic                out_valid;
  logic                out_ready;
  logic [2*WIDTH-1:0]  out;
  logic                busy;

  seq_mult_pipe_ctrl #(.WIDTH(WIDTH), .SIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int prev_acc_cyc = 0;
  bit lat_pend = 1'b0;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: accept tracking, latency check and scoreboard pop.
  always @(negedge clk) begin
    if (rst) begin
      lat_pend = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        prev_acc_cyc = acc_cyc;
        acc_cyc      = cyc;
        lat_pend     = 1'b1;
      end
      if (out_valid && lat_pend) begin
        chk("latency", cyc - acc_cyc, 32'd9);
        lat_pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          chk("product", {16'd0, out}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp);
    bit ok;
    in1 = a; in2 = b; is_signed = s; in_valid = 1'b1;
    wait_accept(ok);
    if (ok) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; is_signed = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out", {16'd0, out}, 32'd0);

    // Directed products
    issue(8'd13, 8'd11, 1'b0, 16'h008F);
    chk("busy_in_flight", {31'd0, busy}, 32'd1);
    drain();
    issue(8'd255, 8'd255, 1'b0, 16'hFE01); drain();
    issue(8'd0, 8'd200, 1'b0, 16'h0000); drain();
    issue(8'h80, 8'h80, 1'b1, 16'h4000); drain();
    issue(8'hFD, 8'd5, 1'b1, 16'hFFF1); drain();
    issue(8'd127, 8'hFF, 1'b1, 16'hFF81); drain();
    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01); drain();
    chk("idle_hold_out", {16'd0, out}, 32'h0000FE01);

    // Backpressure in DONE with a competing in_valid
    out_ready = 1'b0;
    issue(8'd9, 8'd10, 1'b0, 16'd90);
    wait_out_valid();
    @(posedge clk); #1;
    in1 = 8'd3; in2 = 8'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out", {16'd0, out}, 32'd90);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_queue_empty", exp_q.size(), 32'd0);

    // Reset in the 4th BUSY cycle discards the operation
    in1 = 8'd9; in2 = 8'd9; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out", {16'd0, out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    issue(8'd6, 8'd7, 1'b0, 16'h002A); drain();

    // Back-to-back with in_valid held high
    begin
      bit ok;
      in1 = 8'd2; in2 = 8'd3; is_signed = 1'b0; in_valid = 1'b1;
      wait_accept(ok);
      if (ok) exp_q.push_back(16'd6);
      @(posedge clk); #1;
      in1 = 8'd4; in2 = 8'd5;
      wait_accept(ok);
      if (ok) exp_q.push_back(16'd20);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
      chk("b2b_spacing", acc_cyc - prev_acc_cyc, 32'd10);
    end

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_mult_pipe_ctrl.md
SEQ_MULT_PIPE_CTRL -- requirements
Module: seq_mult_pipe_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter SIGNED_EN, default 1; when 1 the is_signed input is honoured, and when 0 it is ignored and all operations are unsigned.
REQ-003 clk  input  1  the only clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  an operand pair is presented.
REQ-006 in_ready  output  1  the block can accept an operand pair.
REQ-007 in1  input  WIDTH  multiplier operand.
REQ-008 in2  input  WIDTH  multiplicand operand.
REQ-009 is_signed  input  1  treat in1/in2 as two's complement, sampled with the operands.
REQ-010 out_valid  output  1  out holds a finished product.
REQ-011 out_ready  input  1  the consumer accepts out.
REQ-012 out  output  2*WIDTH  product; signed products SHALL be two's complement.
REQ-013 busy  output  1  high in BUSY and DONE states.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, BUSY and DONE, with in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-015 Input handshake: in_valid && in_ready at an edge SHALL capture in1, in2 and is_signed, clear the accumulator, zero the step counter, and move to BUSY.
REQ-016 Capture (signed): each operand SHALL be replaced by its magnitude (-2^(WIDTH-1) gives magnitude 2^(WIDTH-1) in WIDTH unsigned bits), and neg = sign(in1) XOR sign(in2) SHALL be stored.
REQ-017 BUSY step: if a[0]==1 then acc += b; then a >>= 1 (WIDTH bits), b <<= 1 (2*WIDTH bits), step counter +1.
REQ-018 Arithmetic: acc and b SHALL be 2*WIDTH bits; no step shall overflow, and no truncation beyond 2*WIDTH bits is permitted.
REQ-019 Exactly WIDTH BUSY steps SHALL execute (no early termination); after the WIDTH-th step the state SHALL become DONE, with acc negated (two's complement) if neg==1.
REQ-020 Latency: out_valid SHALL first be high WIDTH+1 edges after the input-handshake edge.
REQ-021 In DONE, out and out_valid SHALL be held stable until out_ready==1; the output handshake edge SHALL return the FSM to IDLE.
REQ-022 out SHALL hold the last product in IDLE and BUSY, and is only defined when out_valid==1.
REQ-023 in_valid while in BUSY or DONE SHALL be ignored: no capture, and no change to the operation in flight.
REQ-024 Throughput: at most one operation in flight; the minimum period between input handshakes SHALL be WIDTH+2 cycles when out_ready is held high.
REQ-025 A zero operand SHALL still take the full WIDTH steps and produce out==0.
REQ-026 An out_ready pulse while not in DONE SHALL have no effect.

Reset
REQ-027 rst==1 at an edge SHALL force IDLE, clear acc, operands, neg and step counter, and set out to 0; after the edge in_ready==1, out_valid==0 and busy==0.
REQ-028 rst SHALL take priority over every handshake at the same edge, including reset mid-BUSY and reset in DONE with out_ready==1; the in-flight result is discarded.
REQ-029 Power-up register values SHALL equal the reset values.

Verification (WIDTH=8, SIGNED_EN=1)
REQ-030 Unsigned 13*11, out_ready=1 -> out_valid high 9 edges after accept, out=16'h008F.
REQ-031 Unsigned 255*255 -> out=16'hFE01; 0*200 -> out=16'h0000 with the same 9-edge latency.
REQ-032 Signed -128*-128 -> 16'h4000; signed -3*5 -> 16'hFFF1; signed 127*-1 -> 16'hFF81.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE -> out/out_valid stable throughout, in_ready=0 and a new in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-034 rst asserted in the 4th BUSY cycle -> next cycle in_ready=1, out_valid=0, out=0; a following 6*7 -> out=16'h002A.
REQ-035 Back-to-back: in_valid held high with operand pairs (2,3) then (4,5) -> products 6 then 20, with input handshakes exactly 10 edges apart.
